// File: rtl/rv32_wb_retire.sv
// rv32_wb_retire: RV32 writeback/retire stage with register file, forwarding, run-state FSM and perf counters
module rv32_wb_retire #(
  parameter logic [31:0] NOP_CODE = 32'h0000_0013,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      alu_res_in,
  input  logic [31:0]      bshift_in,
  input  logic [31:0]      pc_ret_in,
  input  logic [31:0]      data_res_in,
  input  logic [2:0]       rf_in,
  input  logic             pc_hlt_in,
  input  logic [31:0]      code_in,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [31:0]      rs1_data,
  output logic [31:0]      rs2_data,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic             halted,
  output logic [1:0]       run_state
);
  typedef enum logic [1:0] {WAIT = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_t;
  state_t           state_q, state_d;
  logic [31:0]      regs_q [32];
  logic [31:0]      regs_d [32];
  logic [CNT_W-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic             active;
  always_comb begin
    wb_rd     = code_in[11:7];
    wb_data   = rf_in[2] ? (rf_in[1] ? data_res_in : pc_ret_in) : (rf_in[1] ? bshift_in : alu_res_in);
    active    = (state_q != HALTED) && !pc_hlt_in;
    wb_en     = active && rf_in[0] && (wb_rd != 5'd0);
    rs1_data  = (rs1_addr == 5'd0) ? 32'd0 : (wb_en && rs1_addr == wb_rd) ? wb_data : regs_q[rs1_addr];
    rs2_data  = (rs2_addr == 5'd0) ? 32'd0 : (wb_en && rs2_addr == wb_rd) ? wb_data : regs_q[rs2_addr];
    // WAIT ignores the halt=1 the MEM/WB register holds coming out of reset
    state_d   = (state_q == WAIT) ? (pc_hlt_in ? WAIT : RUN) :
                (state_q == RUN)  ? (pc_hlt_in ? HALTED : RUN) : HALTED;
    regs_d    = regs_q;
    if (wb_en) regs_d[wb_rd] = wb_data;
    cycle_d   = cycle_q + CNT_W'(state_q == RUN);
    instret_d = instret_q + CNT_W'(active && code_in != NOP_CODE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= WAIT;
      cycle_q   <= '0;
      instret_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      regs_q    <= regs_d;
    end
  end
  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
  assign halted      = (state_q == HALTED);
  assign run_state   = state_q;
endmodule

// File: tb/tb_rv32_wb_retire.sv
// tb_rv32_wb_retire: directed self-checking bench for rv32_wb_retire
module tb_rv32_wb_retire;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst_n, rst4_n, hlt, hlt4;
  logic [31:0] alu, bsh, pcr, dat, code;
  logic [2:0]  rf;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, wdat, rd1_4, rd2_4, wdat_4;
  logic        wen, hltd, wen_4, hltd_4;
  logic [4:0]  wrd, wrd_4;
  logic [63:0] cyc, ins;
  logic [3:0]  cyc_4, ins_4;
  logic [1:0]  rs, rs_4;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] sel_val [4];
  logic [9:0]  live_pat;

  rv32_wb_retire dut (
    .clk(clk), .rst_n(rst_n), .alu_res_in(alu), .bshift_in(bsh), .pc_ret_in(pcr),
    .data_res_in(dat), .rf_in(rf), .pc_hlt_in(hlt), .code_in(code),
    .rs1_addr(ra1), .rs2_addr(ra2), .rs1_data(rd1), .rs2_data(rd2),
    .wb_en(wen), .wb_rd(wrd), .wb_data(wdat), .cycle_cnt(cyc), .instret_cnt(ins),
    .halted(hltd), .run_state(rs));

  rv32_wb_retire #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .alu_res_in(alu), .bshift_in(bsh), .pc_ret_in(pcr),
    .data_res_in(dat), .rf_in(rf), .pc_hlt_in(hlt4), .code_in(code),
    .rs1_addr(ra1), .rs2_addr(ra2), .rs1_data(rd1_4), .rs2_data(rd2_4),
    .wb_en(wen_4), .wb_rd(wrd_4), .wb_data(wdat_4), .cycle_cnt(cyc_4), .instret_cnt(ins_4),
    .halted(hltd_4), .run_state(rs_4));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; rst4_n = 0; hlt = 1; hlt4 = 1; rf = 3'b000; code = NOP;
    alu = 0; bsh = 0; pcr = 0; dat = 0; ra1 = 0; ra2 = 0;
    repeat (2) step();
    rst_n = 1;
    #1;
    chk("rst_state", rs, 0);
    chk("rst_halted", hltd, 0);
    chk("rst_cyc", cyc, 0);
    chk("rst_ins", ins, 0);
    chk("rst_wb_en", wen, 0);
    chk("rst_wb_rd", wrd, 0);
    chk("rst_wb_data", wdat, 0);
    chk("rst_rs1", rd1, 0);
    // halt=1 in WAIT with a write request: must be ignored
    rf = 3'b001; code = 32'h0000_0093; alu = 32'haaaa_5555; ra1 = 5'd1;
    #1 chk("wait_wb_en", wen, 0);
    repeat (5) step();
    chk("wait_state", rs, 0);
    chk("wait_cyc", cyc, 0);
    chk("wait_ins", ins, 0);
    rf = 3'b000; code = NOP;
    #1 chk("wait_no_write", rd1, 0);
    hlt = 0;
    step();
    chk("run_state", rs, 1);
    chk("run_cyc0", cyc, 0);
    // same-cycle bypass on both ports
    rf = 3'b001; alu = 32'h1234_5678; code = 32'h0000_0293; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    chk("byp_wb_en", wen, 1);
    chk("byp_wb_rd", wrd, 5);
    chk("byp_rs1", rd1, 32'h1234_5678);
    chk("byp_rs2", rd2, 32'h1234_5678);
    step();
    rf = 3'b000; code = NOP; ra2 = 5'd6;
    #1;
    chk("arr_rs1", rd1, 32'h1234_5678);
    chk("arr_rs2_x6", rd2, 0);
    // writeback select sweep to x7
    alu = 32'ha1a1_0001; bsh = 32'hb2b2_0002; pcr = 32'hc3c3_0003; dat = 32'hd4d4_0004;
    sel_val[0] = 32'ha1a1_0001; sel_val[1] = 32'hb2b2_0002;
    sel_val[2] = 32'hc3c3_0003; sel_val[3] = 32'hd4d4_0004;
    ra1 = 5'd7;
    for (int s = 0; s < 4; s++) begin
      rf = {2'(s), 1'b1}; code = 32'h0000_0393;
      #1 chk($sformatf("sel%0d_wb_data", s), wdat, sel_val[s]);
      step();
      rf = 3'b000; code = NOP;
      #1 chk($sformatf("sel%0d_x7", s), rd1, sel_val[s]);
    end
    rf = 3'b001; code = 32'h0010_0013; ra1 = 5'd0;
    #1;
    chk("x0_wb_en", wen, 0);
    chk("x0_rs1", rd1, 0);
    step();
    chk("x0_after", rd1, 0);
    // fresh reset: array cleared, then 10 RUN cycles with 6 live instructions
    rf = 3'b000; code = NOP; rst_n = 0; hlt = 1;
    step();
    rst_n = 1; ra1 = 5'd7;
    #1 chk("rst_x7", rd1, 0);
    hlt = 0;
    step();
    live_pat = 10'b01_0101_1011;
    for (int i = 0; i < 10; i++) begin
      code = live_pat[i] ? 32'h0010_0093 : NOP;
      step();
    end
    code = NOP;
    chk("cnt_ins6", ins, 6);
    chk("cnt_cyc10", cyc, 10);
    // halt slot with a write request to x3
    rf = 3'b001; alu = 32'hdead_beef; code = 32'h0000_0193; hlt = 1; ra1 = 5'd3;
    #1;
    chk("hlt_wb_en", wen, 0);
    chk("hlt_rs1", rd1, 0);
    step();
    chk("hlt_halted", hltd, 1);
    chk("hlt_state", rs, 2);
    chk("hlt_cyc", cyc, 11);
    chk("hlt_ins", ins, 6);
    hlt = 0;
    #1 chk("halted_wb_en", wen, 0);
    repeat (3) step();
    chk("frz_halted", hltd, 1);
    chk("frz_cyc", cyc, 11);
    chk("frz_ins", ins, 6);
    chk("frz_x3", rd1, 0);
    rst_n = 0; hlt = 1; rf = 3'b000; code = NOP;
    step();
    rst_n = 1;
    #1;
    chk("rst2_state", rs, 0);
    chk("rst2_halted", hltd, 0);
    chk("rst2_cyc", cyc, 0);
    chk("rst2_ins", ins, 0);
    // 4-bit counter wrap
    rst4_n = 1; hlt4 = 0;
    step();
    chk("w4_run", rs_4, 1);
    repeat (15) step();
    chk("w4_cyc15", cyc_4, 4'hf);
    step();
    chk("w4_wrap", cyc_4, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rv32_wb_retire.md
# rv32_wb_retire

Writeback and retire stage of the 5-stage RV32 pipeline, sitting directly after the MEM/WB pipeline register. Selects the writeback value from the four MEM/WB result buses, owns the 32x32 integer register file (two combinational read ports for decode, with same-cycle write bypass), and drives the forwarding bus toward EX. Also tracks processor run state (WAIT/RUN/HALTED) from the halt flag and keeps the cycle and instructions-retired counters.

## Interface
- NOP_CODE, 32'h0000_0013, bubble encoding (addi x0,x0,0); not counted as retired
- CNT_W, 64, width of cycle and instret counters

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- alu_res_in  in  32  ALU result from MEM/WB
- bshift_in  in  32  barrel-shifter result from MEM/WB
- pc_ret_in  in  32  return address (PC+4) from MEM/WB
- data_res_in  in  32  load data from MEM/WB
- rf_in  in  3  [2:1] writeback select, [0] register write enable
- pc_hlt_in  in  1  1 = slot is a halt marker; 0 = live slot
- code_in  in  32  instruction in WB; rd = code_in[11:7]
- rs1_addr, rs2_addr  in  5 each  decode read addresses
- rs1_data, rs2_data  out  32 each  read data
- wb_en  out  1  forwarding valid (write occurs this cycle)
- wb_rd  out  5  forwarding destination
- wb_data  out  32  forwarding/write value
- cycle_cnt  out  CNT_W  cycles spent in RUN
- instret_cnt  out  CNT_W  retired instructions
- halted  out  1  state == HALTED
- run_state  out  2  0 WAIT, 1 RUN, 2 HALTED

## Operation
- Writeback select rf_in[2:1]: 00 alu_res_in, 01 bshift_in, 10 pc_ret_in, 11 data_res_in. wb_data is this mux, always driven.
- active = (run_state != HALTED) && !pc_hlt_in.
- wb_en = active && rf_in[0] && (code_in[11:7] != 0); wb_rd = code_in[11:7].
- Register file: 32 entries; x0 reads 0 always, never written. On posedge, if wb_en, reg[wb_rd] <= wb_data.
- Read ports combinational: addr 0 -> 0; else if wb_en && addr == wb_rd -> wb_data (bypass); else reg[addr]. Both ports independent, may hit same address.
- FSM:
  - WAIT (reset state): pipeline register comes out of reset with halt=1; ignore it. pc_hlt_in=0 -> RUN; else stay.
  - RUN: pc_hlt_in=1 -> HALTED; else stay.
  - HALTED: sticky; only rst_n=0 leaves (-> WAIT).
- Halt slot: write suppressed even if rf_in[0]=1; not counted.
- cycle_cnt: +1 on every posedge with run_state == RUN (includes the cycle the halt is seen).
- instret_cnt: +1 when active && code_in != NOP_CODE (includes the WAIT->RUN transition cycle).
- Counters wrap modulo 2^CNT_W; no saturation, no flag.

## Timing
- Reset (rst_n=0 sampled at posedge): all 31 registers 0, cycle_cnt 0, instret_cnt 0, run_state WAIT, halted 0. Reset overrides any write or count that cycle. Mid-run reset discards halted status and counts.
- Combinational outputs after reset with inputs at MEM/WB reset values (halt=1, rf=0, NOP): wb_en 0, wb_rd 0, wb_data 0, rs*_data 0.
- Write latency: value visible via bypass in the same cycle; in array from next cycle.
- halted asserts the cycle after the posedge that sampled pc_hlt_in=1 in RUN.
- No backpressure; one slot consumed per cycle.

## Test plan
- Reset then hold pc_hlt_in=1 5 cycles -> run_state stays WAIT, counters 0, no writes; drop to 0 -> RUN next cycle.
- rf_in=3'b001, alu_res_in=32'h1234_5678, code rd=5, rs1_addr=5 same cycle -> rs1_data=32'h1234_5678 (bypass), wb_en=1; next cycle read from array identical.
- Sweep rf_in[2:1] 00/01/10/11 with distinct bus values to rd=7 -> x7 holds each selected value in turn; rd=0 with write enable -> wb_en=0, x0 reads 0.
- RUN for 10 cycles: 6 live non-NOP, 4 NOP_CODE -> instret_cnt=6, cycle_cnt=10.
- In RUN assert pc_hlt_in=1 with rf_in=3'b001, rd=3 -> no write to x3, halted=1 next cycle, counters frozen thereafter; rst_n=0 -> WAIT, all cleared.
- Preload cycle_cnt near wrap (CNT_W=4 instance, 15 RUN cycles then 1 more) -> cycle_cnt reads 0.
